// File: rtl/hex_marquee_if.sv
// Byte-in / window-out bundle between the UART receive path, the marquee
// controller and the five alpha_display decoders.
interface hex_marquee_if;
   // A byte on in_data moves on any rising edge where in_valid && in_ready;
   // the sender holds in_valid/in_data stable until that edge.
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       clear;
   logic [7:0] char4;
   logic [7:0] char3;
   logic [7:0] char2;
   logic [7:0] char1;
   logic [7:0] char0;
   logic [4:0] msg_len;
   logic       overflow;

   modport slave (
      input  in_valid, in_data, clear,
      output in_ready, char4, char3, char2, char1, char0, msg_len, overflow
   );

   modport master (
      output in_valid, in_data, clear,
      input  in_ready, char4, char3, char2, char1, char0, msg_len, overflow
   );
endinterface

// File: rtl/hex_marquee.sv
// Double-buffered ASCII message controller for a five-digit alpha display:
// static for short messages, left-scrolling with a blank separator otherwise.
module hex_marquee #(
   parameter int MSG_DEPTH  = 16,
   parameter int SCROLL_DIV = 12_000_000
) (
   input  logic          clk,
   input  logic          rst,
   hex_marquee_if.slave  bus,
   output logic          o_dbg_state
);

   localparam int               IW      = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
   localparam int               TW      = $clog2(SCROLL_DIV);
   localparam logic [4:0]       DEPTH_L = 5'(MSG_DEPTH);
   localparam logic [TW-1:0]    TERM    = TW'(SCROLL_DIV - 1);

   typedef enum logic {
      ST_FILL   = 1'b0,
      ST_COMMIT = 1'b1
   } state_t;

   state_t        r_state;
   logic          r_bank_sel;
   logic [7:0]    r_mem [2][MSG_DEPTH];
   logic [4:0]    r_fill_cnt;
   logic [4:0]    r_msg_len;
   logic [4:0]    r_start;
   logic [TW-1:0] r_timer;
   logic          r_overflow;
   logic [7:0]    r_char [5];

   logic          w_in_ready;
   logic          w_accept;
   logic [7:0]    w_store_byte;
   logic          w_scroll;
   logic [4:0]    w_next_start;
   logic [5:0]    w_ring_len;
   logic [5:0]    w_idx [5];
   logic [7:0]    w_win [5];

   assign w_in_ready   = !rst && !bus.clear && (r_state == ST_FILL);
   assign w_accept     = bus.in_valid && w_in_ready;
   assign w_store_byte = (bus.in_data >= 8'h20 && bus.in_data <= 8'h7E) ? bus.in_data : 8'h3F;
   assign w_scroll     = r_msg_len > 5'd5;
   // Ring length is msg_len+1, so start wraps after reaching msg_len.
   assign w_next_start = (r_start == r_msg_len) ? 5'd0 : r_start + 5'd1;
   assign w_ring_len   = {1'b0, r_msg_len} + 6'd1;

   // Window position k (k=0 is char4) reads ring[(start+k) mod R]; static
   // messages show positions past the end as blanks instead of wrapping.
   always_comb begin
      for (int k = 0; k < 5; k++) begin
         w_idx[k] = {1'b0, r_start} + 6'(k);
         if (!w_scroll) begin
            w_idx[k] = 6'(k);
         end else if (w_idx[k] >= w_ring_len) begin
            w_idx[k] = w_idx[k] - w_ring_len;
         end
         w_win[k] = (w_idx[k] < {1'b0, r_msg_len}) ?
                    r_mem[r_bank_sel][w_idx[k][IW-1:0]] : 8'h20;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_FILL;
         r_bank_sel  <= 1'b0;
         r_msg_len   <= 5'd5;
         r_fill_cnt  <= 5'd0;
         r_start     <= 5'd0;
         r_timer     <= '0;
         r_overflow  <= 1'b0;
         r_mem[0][0] <= 8'h48;
         r_mem[0][1] <= 8'h45;
         r_mem[0][2] <= 8'h4C;
         r_mem[0][3] <= 8'h4C;
         r_mem[0][4] <= 8'h4F;
         r_char[0]   <= 8'h48;
         r_char[1]   <= 8'h45;
         r_char[2]   <= 8'h4C;
         r_char[3]   <= 8'h4C;
         r_char[4]   <= 8'h4F;
      end else begin
         for (int k = 0; k < 5; k++) begin
            r_char[k] <= w_win[k];
         end
         if (bus.clear) begin
            r_state    <= ST_FILL;
            r_msg_len  <= 5'd0;
            r_fill_cnt <= 5'd0;
            r_start    <= 5'd0;
            r_timer    <= '0;
            r_overflow <= 1'b0;
         end else begin
            case (r_state)
               ST_FILL: begin
                  if (w_scroll) begin
                     if (r_timer == TERM) begin
                        r_timer <= '0;
                        r_start <= w_next_start;
                     end else begin
                        r_timer <= r_timer + TW'(1);
                     end
                  end
                  if (w_accept) begin
                     if (bus.in_data == 8'h0D) begin
                        if (r_fill_cnt != 5'd0) begin
                           r_state <= ST_COMMIT;
                        end
                     end else if (bus.in_data != 8'h0A) begin
                        if (r_fill_cnt == DEPTH_L) begin
                           r_overflow <= 1'b1;
                        end else begin
                           r_mem[~r_bank_sel][r_fill_cnt[IW-1:0]] <= w_store_byte;
                           r_fill_cnt <= r_fill_cnt + 5'd1;
                        end
                     end
                  end
               end
               ST_COMMIT: begin
                  // Shadow bank becomes visible; the old active bank is refilled next.
                  r_bank_sel <= ~r_bank_sel;
                  r_msg_len  <= r_fill_cnt;
                  r_fill_cnt <= 5'd0;
                  r_start    <= 5'd0;
                  r_timer    <= '0;
                  r_overflow <= 1'b0;
                  r_state    <= ST_FILL;
               end
               default: r_state <= ST_FILL;
            endcase
         end
      end
   end

   assign bus.in_ready = w_in_ready;
   assign bus.char4    = r_char[0];
   assign bus.char3    = r_char[1];
   assign bus.char2    = r_char[2];
   assign bus.char1    = r_char[3];
   assign bus.char0    = r_char[4];
   assign bus.msg_len  = r_msg_len;
   assign bus.overflow = r_overflow;
   assign o_dbg_state  = (r_state == ST_COMMIT);

endmodule

// File: doc/hex_marquee.md
# hex_marquee

Message controller for the five 7-segment alpha displays on the UART receiver board. Accepts ASCII bytes from the UART receive path over a valid/ready handshake and assembles them into a double-buffered message. It presents a 5-character window (`char4`..`char0`) to the five `alpha_display` decoders. Messages of up to 5 characters are shown static; longer messages scroll left at a fixed rate with wrap-around.

## Interface
- `MSG_DEPTH`, 16: characters per message bank (max message length).
- `SCROLL_DIV`, 12_000_000: clock cycles per scroll step (≥2).
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous, active-high reset; one clock; reset is synchronous and active-high.
- `in_valid` input 1: byte offered on `in_data`.
- `in_data` input 8: ASCII byte.
- `in_ready` output 1: byte accepted on an edge where `in_valid && in_ready`.
- `clear` input 1: synchronous; blanks the display and discards the partial message.
- `char4`..`char0` output 8 each: ASCII for HEX4 (leftmost) .. HEX0; registered.
- `msg_len` output 5: length of the active message.
- `overflow` output 1: sticky; bytes were dropped from the message being filled.

## Operation
- Two banks: active (displayed) and shadow (filling). Bit `bank_sel` selects the active bank.
- FSM states: FILL, COMMIT.
  - FILL: `in_ready`=1. Accepted bytes are handled as follows:
    - 0x0D (CR): triggers commit. If `fill_cnt`==0, CR is ignored (active message kept; state stays FILL).
    - 0x0A (LF): ignored.
    - Other bytes outside 0x20..0x7E: stored as 0x3F '?'.
    - Printable bytes: stored at `shadow[fill_cnt]`, then `fill_cnt`++.
    - If `fill_cnt`==MSG_DEPTH, the byte is dropped and `overflow` is set. `in_ready` stays 1.
  - FILL -> COMMIT on an accepted CR with `fill_cnt`>0.
  - COMMIT (exactly one cycle): `in_ready`=0. On the edge leaving COMMIT:
    - `bank_sel` flips; `msg_len`=`fill_cnt`.
    - `fill_cnt`=0; `start`=0; scroll timer=0; `overflow`=0.
    - Next state is FILL.
- Window selection:
  - Ring length R = `msg_len`+1 (message followed by one 0x20 separator).
  - `char(4-k)` = ring[(`start`+k) mod R] for k=0..4.
  - If `msg_len`≤5: static. `char4` shows the first character, and unused positions are 0x20. `start` is held at 0.
  - If `msg_len`==0: all five outputs are 0x20.
- Scroll: only when `msg_len`>5.
  - Timer counts 0..SCROLL_DIV-1.
  - On the edge where timer==SCROLL_DIV-1: timer returns to 0 and `start` = (`start`+1 == R) ? 0 : `start`+1.
- `clear` (priority over everything except `rst`):
  - Active message becomes empty (`msg_len`=0, outputs all 0x20).
  - `fill_cnt`=0, `overflow`=0, state=FILL, timer=0, `start`=0.
  - `in_ready` is forced 0 while `clear`=1; a byte offered in that cycle is not accepted.
- Reset values:
  - Active bank preloaded with "HELLO"; `msg_len`=5.
  - `char4..char0` = 0x48, 0x45, 0x4C, 0x4C, 0x4F.
  - State=FILL; `in_ready`=0 during reset, 1 on the first cycle after.
  - `fill_cnt`=0, `overflow`=0, `start`=0, timer=0.
  - Contents of shadow bank and unused active entries: don't-care.
- A reset or clear arriving mid-fill discards the partial message; no partial content ever reaches the display.

## Timing
- Byte handshake: zero-latency acceptance (combinational `in_ready` from state and `clear`); one byte per cycle in FILL.
- A CR accepted at edge N gives:
  - COMMIT during cycle N..N+1.
  - Bank flip at edge N+1.
  - New characters on the outputs from edge N+2.
  - `in_ready` low only during the COMMIT cycle.
- A byte offered during COMMIT is held by the sender and accepted at the first FILL cycle.
- Scroll step: `start` updates at the terminal-count edge; outputs reflect the new `start` one edge later. Consecutive output changes are therefore exactly SCROLL_DIV cycles apart.
- `clear` asserted at edge N: outputs are 0x20 from edge N+1.
- Outputs change only on `clk` edges; no glitches on `char*`.

## Test plan
- Reset, no input, hold 100 cycles -> `char4..0` = 48 45 4C 4C 4F constant; `msg_len`=5; `in_ready`=1.
- SCROLL_DIV=4; send "ABCDEFG",0x0D back-to-back -> `in_ready` low one cycle after CR; outputs "ABCDE" two edges after CR; then every 4 cycles "BCDEF", "CDEFG", "DEFG ", "EFG A", …; after 8 steps back to "ABCDE".
- Send "HI",0x0D -> outputs 48 49 20 20 20 static for 50 cycles; `msg_len`=2.
- MSG_DEPTH=16; send 20 printable bytes then CR -> `overflow`=1 after byte 17; after commit `msg_len`=16, `overflow`=0, and bytes 17..20 absent from the scroll sequence.
- Send "XYZ", pulse `clear` with `in_valid` high on the same cycle, then CR -> outputs all 0x20 after clear; CR ignored (`fill_cnt`=0); the clear-cycle byte is not accepted.
- Send 0x01, 'A', 0x0A, CR -> `msg_len`=2; outputs 3F 41 20 20 20; assert `rst` mid-scroll of a 10-char message -> "HELLO" on the edge after `rst` deasserts.
